// File: rtl/data_mem_pkg.sv
// Shared types, init-pattern selectors and the init-word helper for the
// Salamander dual-port data memory.
package data_mem_pkg;

   typedef enum logic {INIT, RUN} mem_state_t;

   localparam int INIT_ZERO  = 0;
   localparam int INIT_INDEX = 1;

   // Post-reset content of word idx, already masked to data_size bits.
   function automatic logic [63:0] init_word(input int unsigned idx,
                                             input int unsigned data_size,
                                             input int          mode);
      logic [63:0] mask;
      if (data_size >= 64) mask = '1;
      else                 mask = (64'd1 << data_size) - 64'd1;
      if (mode == INIT_INDEX) return 64'(idx) & mask;
      else                    return '0;
   endfunction

endpackage

// File: rtl/data_mem_init_seq.sv
// Post-reset init sweep: writes one word per cycle, then enters RUN.
// Also owns READY and the sticky WR_DROP flag.
module data_mem_init_seq
   import data_mem_pkg::*;
#(
   parameter int DATA_SIZE = 8,
   parameter int ADDR_SIZE = 5,
   parameter int INIT_MODE = INIT_INDEX
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 we_a,
   output logic                 init_we,
   output logic [ADDR_SIZE-1:0] init_addr,
   output logic [DATA_SIZE-1:0] init_data,
   output logic                 ready,
   output logic                 wr_drop,
   output mem_state_t           state
);

   mem_state_t           state_nxt;
   logic [ADDR_SIZE-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state   <= INIT;
         cnt     <= '0;
         wr_drop <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == INIT) cnt <= cnt + 1'b1;
         if (state == INIT && we_a) wr_drop <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         INIT:    if (cnt == {ADDR_SIZE{1'b1}}) state_nxt = RUN;
         RUN:     state_nxt = RUN;
         default: state_nxt = INIT;
      endcase
   end

   // The array is only touched while out of reset, so the sweep is gated by rstn.
   always_comb begin
      init_we   = rstn && (state == INIT);
      init_addr = cnt;
      init_data = DATA_SIZE'(init_word(32'(cnt), DATA_SIZE, INIT_MODE));
      ready     = (state == RUN);
   end

endmodule

// File: rtl/data_mem_dp.sv
// Salamander data memory: port A read/write, port B read-only (debug/DMA),
// selectable read latency, cleared by an init sweep after reset.
module data_mem_dp
   import data_mem_pkg::*;
#(
   parameter int DATA_SIZE = 8,
   parameter int ADDR_SIZE = 5,
   parameter int RD_LAT    = 1,
   parameter int INIT_MODE = INIT_INDEX
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 W_A,
   input  logic [ADDR_SIZE-1:0] ADDR_A,
   input  logic [DATA_SIZE-1:0] DATA_WR_A,
   output logic [DATA_SIZE-1:0] DATA_RD_A,
   input  logic                 RE_B,
   input  logic [ADDR_SIZE-1:0] ADDR_B,
   output logic [DATA_SIZE-1:0] DATA_RD_B,
   output logic                 RVALID_B,
   output logic                 READY,
   output logic                 WR_DROP
);

   localparam int MEM_SIZE = 2 ** ADDR_SIZE;

   (* preserve *) logic [DATA_SIZE-1:0] mem [MEM_SIZE];

   logic                 init_we;
   logic [ADDR_SIZE-1:0] init_addr;
   logic [DATA_SIZE-1:0] init_data;
   mem_state_t           fsm_state;
   logic                 run;

   data_mem_init_seq #(
      .DATA_SIZE (DATA_SIZE),
      .ADDR_SIZE (ADDR_SIZE),
      .INIT_MODE (INIT_MODE)
   ) u_init_seq (
      .clk       (clk),
      .rstn      (rstn),
      .we_a      (W_A),
      .init_we   (init_we),
      .init_addr (init_addr),
      .init_data (init_data),
      .ready     (READY),
      .wr_drop   (WR_DROP),
      .state     (fsm_state)
   );

   assign run = (fsm_state == RUN);

   // No reset on the array: the sweep owns clearing. Core writes only in RUN.
   always_ff @(posedge clk) begin
      if (init_we)
         mem[init_addr] <= init_data;
      else if (rstn && run && W_A)
         mem[ADDR_A] <= DATA_WR_A;
   end

   generate
      if (RD_LAT == 0) begin : g_comb_rd
         always_comb begin
            DATA_RD_A = run ? mem[ADDR_A] : '0;
            DATA_RD_B = run ? mem[ADDR_B] : '0;
            RVALID_B  = RE_B & run;
         end
      end else begin : g_reg_rd
         // Non-blocking reads of mem give read-first behaviour on both ports.
         always_ff @(posedge clk) begin
            if (!rstn) begin
               DATA_RD_A <= '0;
               DATA_RD_B <= '0;
               RVALID_B  <= 1'b0;
            end else begin
               RVALID_B  <= RE_B & run;
               DATA_RD_A <= run ? mem[ADDR_A] : '0;
               if (!run)      DATA_RD_B <= '0;
               else if (RE_B) DATA_RD_B <= mem[ADDR_B];
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_data_mem_dp.sv
// Bench for data_mem_dp: default instance with registered reads plus two
// 4-bit combinational-read instances (zero init and index init).
module tb_data_mem_dp;

   logic       clk;
   logic       rstn;

   logic       w_a;
   logic [4:0] addr_a;
   logic [7:0] data_wr_a;
   logic [7:0] data_rd_a;
   logic       re_b;
   logic [4:0] addr_b;
   logic [7:0] data_rd_b;
   logic       rvalid_b;
   logic       ready;
   logic       wr_drop;

   logic       s_we;
   logic [4:0] s_addr_a;
   logic [3:0] s_data;
   logic       s_re;
   logic [4:0] s_addr_b;
   logic [3:0] z_rd_a, z_rd_b, t_rd_a, t_rd_b;
   logic       z_rvalid, t_rvalid, z_ready, t_ready, z_drop, t_drop;

   int checks;
   int failures;
   logic [7:0] exp_q[$];

   data_mem_dp dut (
      .clk(clk), .rstn(rstn),
      .W_A(w_a), .ADDR_A(addr_a), .DATA_WR_A(data_wr_a), .DATA_RD_A(data_rd_a),
      .RE_B(re_b), .ADDR_B(addr_b), .DATA_RD_B(data_rd_b), .RVALID_B(rvalid_b),
      .READY(ready), .WR_DROP(wr_drop)
   );

   data_mem_dp #(.DATA_SIZE(4), .ADDR_SIZE(5), .RD_LAT(0), .INIT_MODE(0)) dut_z (
      .clk(clk), .rstn(rstn),
      .W_A(s_we), .ADDR_A(s_addr_a), .DATA_WR_A(s_data), .DATA_RD_A(z_rd_a),
      .RE_B(s_re), .ADDR_B(s_addr_b), .DATA_RD_B(z_rd_b), .RVALID_B(z_rvalid),
      .READY(z_ready), .WR_DROP(z_drop)
   );

   data_mem_dp #(.DATA_SIZE(4), .ADDR_SIZE(5), .RD_LAT(0), .INIT_MODE(1)) dut_t (
      .clk(clk), .rstn(rstn),
      .W_A(s_we), .ADDR_A(s_addr_a), .DATA_WR_A(s_data), .DATA_RD_A(t_rd_a),
      .RE_B(s_re), .ADDR_B(s_addr_b), .DATA_RD_B(t_rd_b), .RVALID_B(t_rvalid),
      .READY(t_ready), .WR_DROP(t_drop)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // driver tasks
   task automatic issue_b(input logic [4:0] a, input logic [7:0] exp);
      re_b   = 1'b1;
      addr_b = a;
      exp_q.push_back(exp);
      tick();
      re_b   = 1'b0;
   endtask

   task automatic init_sweep(input string tag, input int drop_at);
      for (int c = 1; c <= 32; c++) begin
         tick();
         check({tag, "_ready"}, {31'd0, ready}, {31'd0, (c >= 32)});
         if (c == drop_at) begin
            w_a = 1'b1; addr_a = 5'd3; data_wr_a = 8'hAA;
         end else begin
            w_a = 1'b0;
         end
         if (c == 5) begin
            re_b = 1'b1; addr_b = 5'd5; s_re = 1'b1;
            #1;
            check({tag, "_z_rvalid_init"}, {31'd0, z_rvalid}, 32'd0);
            check({tag, "_t_rd_a_init"}, {28'd0, t_rd_a}, 32'd0);
         end else if (c == 6) begin
            check({tag, "_rvalid_b_init"}, {31'd0, rvalid_b}, 32'd0);
            re_b = 1'b0; s_re = 1'b0;
         end
      end
   endtask

   initial begin
      checks = 0; failures = 0;
      rstn = 1'b0; w_a = 1'b0; addr_a = '0; data_wr_a = '0; re_b = 1'b0; addr_b = '0;
      s_we = 1'b0; s_addr_a = 5'd17; s_data = '0; s_re = 1'b0; s_addr_b = '0;

      // scoreboard monitor: every RVALID_B must match the oldest expected word
      fork
         forever begin
            @(negedge clk);
            if (rvalid_b) begin
               if (exp_q.size() == 0) begin
                  check("rvalid_b_unexpected", {31'd0, rvalid_b}, 32'd0);
               end else begin
                  logic [7:0] e;
                  e = exp_q.pop_front();
                  check("data_rd_b", {24'd0, data_rd_b}, {24'd0, e});
               end
            end
         end
      join_none

      repeat (3) tick();
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_wr_drop", {31'd0, wr_drop}, 32'd0);
      check("rst_rvalid_b", {31'd0, rvalid_b}, 32'd0);
      check("rst_data_rd_a", {24'd0, data_rd_a}, 32'd0);
      check("rst_data_rd_b", {24'd0, data_rd_b}, 32'd0);
      rstn = 1'b1;

      // init sweep with a write attempt at cycle 10
      init_sweep("init1", 10);
      check("wr_drop_set", {31'd0, wr_drop}, 32'd1);

      issue_b(5'd0,  8'h00);
      issue_b(5'd5,  8'h05);
      issue_b(5'd31, 8'h1F);
      issue_b(5'd3,  8'h03);
      check("rd_a_addr3", {24'd0, data_rd_a}, 32'h03);

      // cross-port and same-port collision at address 7
      w_a = 1'b1; addr_a = 5'd7; data_wr_a = 8'h5C;
      re_b = 1'b1; addr_b = 5'd7; exp_q.push_back(8'h07);
      tick();
      check("rd_a_collide_old", {24'd0, data_rd_a}, 32'h07);
      w_a = 1'b0; exp_q.push_back(8'h5C);
      tick();
      check("rd_a_collide_new", {24'd0, data_rd_a}, 32'h5C);
      re_b = 1'b0;
      tick();
      check("rd_b_hold", {24'd0, data_rd_b}, 32'h5C);
      w_a = 1'b1; addr_a = 5'd31; data_wr_a = 8'hE1;
      tick();
      w_a = 1'b0;
      issue_b(5'd31, 8'hE1);
      check("wr_drop_run_write", {31'd0, wr_drop}, 32'd1);

      // combinational-read instances, 4-bit words
      for (int i = 0; i < 32; i++) begin
         s_addr_a = 5'(i);
         #1;
         if (z_rd_a !== 4'd0) check("z_zero_init", {28'd0, z_rd_a}, 32'd0);
      end
      check("z_ready", {31'd0, z_ready}, 32'd1);
      tick();
      s_addr_a = 5'd17; #1;
      check("t_addr17", {28'd0, t_rd_a}, 32'h1);
      s_addr_a = 5'd5; #1;
      check("t_addr5_no_edge", {28'd0, t_rd_a}, 32'h5);
      s_re = 1'b1; s_addr_b = 5'd20; #1;
      check("t_rvalid_run", {31'd0, t_rvalid}, 32'd1);
      check("t_rd_b_addr20", {28'd0, t_rd_b}, 32'h4);
      s_re = 1'b0;
      s_we = 1'b1; s_addr_a = 5'd2; s_data = 4'h9; #1;
      check("t_same_cycle_old", {28'd0, t_rd_a}, 32'h2);
      tick();
      s_we = 1'b0; #1;
      check("t_after_write", {28'd0, t_rd_a}, 32'h9);
      check("z_after_write", {28'd0, z_rd_a}, 32'h9);

      // reset mid-init at cnt=12 restarts the full sweep
      rstn = 1'b0;
      tick();
      check("rst2_ready", {31'd0, ready}, 32'd0);
      check("rst2_rd_b", {24'd0, data_rd_b}, 32'd0);
      rstn = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         w_a = (c == 2);
         addr_a = 5'd9; data_wr_a = 8'h77;
         tick();
      end
      w_a = 1'b0;
      check("mid_init_drop", {31'd0, wr_drop}, 32'd1);
      rstn = 1'b0;
      tick();
      check("mid_rst_drop_clr", {31'd0, wr_drop}, 32'd0);
      rstn = 1'b1;
      init_sweep("init2", 0);
      check("init2_no_drop", {31'd0, wr_drop}, 32'd0);
      issue_b(5'd7, 8'h07);
      issue_b(5'd9, 8'h09);
      issue_b(5'd31, 8'h1F);

      repeat (3) tick();
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/data_mem_dp.md
Name: data_mem_dp

Overview:
Parametrised data memory for the Salamander core. It has one read/write port (A) and one read-only port (B), used by the debug/DMA path.
- Selectable read latency (0 or 1 cycle).
- Selectable init pattern.
- Memory is cleared by a one-word-per-cycle init sequencer after reset, not by a full-array reset.
- READY tells the core when the memory is usable.
- WR_DROP is a sticky flag that records writes lost during init.

Parameters:
DATA_SIZE, 8, word width in bits (>=1)
ADDR_SIZE, 5, address width; MEM_SIZE = 2**ADDR_SIZE words
RD_LAT, 1, read latency of both ports: 0 = combinational, 1 = registered
INIT_MODE, 1, post-reset contents: 0 = all zeros, 1 = mem[i] = i truncated to DATA_SIZE

Ports:
clk  input  1  clock, all logic on posedge
rstn  input  1  reset, synchronous, active-low
W_A  input  1  port A write enable
ADDR_A  input  ADDR_SIZE  port A address
DATA_WR_A  input  DATA_SIZE  port A write data
DATA_RD_A  output  DATA_SIZE  port A read data
RE_B  input  1  port B read request
ADDR_B  input  ADDR_SIZE  port B address
DATA_RD_B  output  DATA_SIZE  port B read data
RVALID_B  output  1  port B read data valid
READY  output  1  init complete, memory usable
WR_DROP  output  1  sticky: a W_A was ignored while READY=0

Behaviour:
- Clock and reset: single clock clk; reset rstn is synchronous, active-low.
- State machine: INIT and RUN, plus init counter cnt[ADDR_SIZE-1:0].
- During rstn=0:
  - state=INIT, cnt=0, READY=0, WR_DROP=0.
  - RVALID_B=0; registered DATA_RD_A/DATA_RD_B = 0.
  - Array is not written.
- INIT state, each cycle with rstn=1:
  - mem[cnt] <= init value; cnt <= cnt+1.
  - When cnt==MEM_SIZE-1, last word written and state <= RUN.
  - READY rises exactly MEM_SIZE cycles after the first clock with rstn=1 (32 for defaults).
- Reset mid-INIT or mid-RUN: on the next edge, return to INIT with cnt=0 and restart the whole sweep. Array contents are rewritten by the sweep.
- Writes during INIT: any W_A=1 is dropped and the array is unchanged by it. WR_DROP <= 1 and stays 1 until reset.
- RUN writes: W_A=1 -> mem[ADDR_A] <= DATA_WR_A at the edge.
- Reads during INIT: DATA_RD_A/DATA_RD_B show 0; RVALID_B stays 0; RE_B is ignored.
- RD_LAT=0:
  - DATA_RD_A = mem[ADDR_A] combinationally; DATA_RD_B = mem[ADDR_B].
  - RVALID_B = RE_B & READY, combinational.
  - Same-cycle write shows the old value until the edge.
- RD_LAT=1:
  - DATA_RD_A registered every RUN cycle from mem[ADDR_A].
  - DATA_RD_B registered only when RE_B=1, otherwise holds its value.
  - RVALID_B <= RE_B & READY.
  - Read-first: a read at the same address as a same-cycle write returns the pre-write data. This applies to both ports.
- Cross-port collision: W_A to address X while port B reads X in the same cycle -> port B returns the old data; the next read returns the new data.
- Width: init value i is truncated to its DATA_SIZE LSBs (e.g. DATA_SIZE=4 gives mem[17]=1).
- No address range check is needed; the full 2**ADDR_SIZE space exists.
- The array carries the synthesis-preserve attribute.

Decomposition:
- Package data_mem_pkg holds:
  - typedef enum {INIT, RUN} mem_state_t
  - localparam INIT_ZERO=0, INIT_INDEX=1
  - function init_word(i) returning the truncated init pattern
- One natural sub-module, data_mem_init_seq:
  - contains the state, cnt, READY and WR_DROP logic
  - outputs init_we, init_addr, init_data into the array write mux
- The array and read registers stay in data_mem_dp.

Test Plan:
- Defaults, rstn low 3 cycles then high -> READY=0 for 32 cycles, 1 on cycle 32. Port B reads of addresses 0, 5, 31 then return 0x00, 0x05, 0x1F with RVALID_B one cycle after RE_B.
- W_A=1, ADDR_A=3, DATA_WR_A=0xAA at cycle 10 after reset release -> WR_DROP=1. After READY, mem[3] reads 0x03.
- RUN, RD_LAT=1: write 0x5C to addr 7 while RE_B=1, ADDR_B=7 in the same cycle -> DATA_RD_B=0x07 next cycle. Repeat the read -> 0x5C. DATA_RD_A follows the same rule.
- Reset asserted for 1 cycle at init cnt=12 -> READY rises 32 cycles after re-release, not 20. WR_DROP cleared.
- INIT_MODE=0, DATA_SIZE=4 -> all words read 0. With INIT_MODE=1, DATA_SIZE=4 -> addr 17 reads 0x1.
- RD_LAT=0: ADDR_A change -> DATA_RD_A updates in the same cycle with no clock edge. RE_B=1 during INIT -> RVALID_B=0.
